// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter onto one register slave.
// Round-robin on ties, per-grant timeout with forced abort ack.
module wb_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [7:0] m0_addr_i,
  input  logic [7:0] m0_dat_i,
  input  logic       m0_stb_i,
  input  logic       m0_we_i,
  output logic [7:0] m0_dat_o,
  output logic       m0_ack_o,
  input  logic [7:0] m1_addr_i,
  input  logic [7:0] m1_dat_i,
  input  logic       m1_stb_i,
  input  logic       m1_we_i,
  output logic [7:0] m1_dat_o,
  output logic       m1_ack_o,
  output logic [7:0] s_addr_o,
  output logic [7:0] s_dat_o,
  output logic       s_stb_o,
  output logic       s_we_o,
  input  logic [7:0] s_dat_i,
  input  logic       s_ack_i,
  output logic [1:0] grant_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    IDLE, GNT0, GNT1, REL
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] tmo_q, tmo_d;
  logic [1:0] grant_q, grant_d;
  logic       rd_ack;
  logic [7:0] rd_dat;
  logic       sel1;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      tmo_q   <= 8'h00;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    s_addr_o  = 8'h00;
    s_dat_o   = 8'h00;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    timeout_o = 1'b0;
    rd_ack    = s_ack_i;
    rd_dat    = s_dat_i;
    sel1      = (state_q == GNT1);
    unique case (state_q)
      IDLE: begin
        if (m0_stb_i && (!m1_stb_i || last_q)) begin
          state_d = GNT0;
          last_d  = 1'b0;
          tmo_d   = 8'h00;
        end else if (m1_stb_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
          tmo_d   = 8'h00;
        end
      end
      GNT0, GNT1: begin
        s_addr_o = sel1 ? m1_addr_i : m0_addr_i;
        s_dat_o  = sel1 ? m1_dat_i  : m0_dat_i;
        s_we_o   = sel1 ? m1_we_i   : m0_we_i;
        s_stb_o  = sel1 ? m1_stb_i  : m0_stb_i;
        tmo_d    = tmo_q + 8'd1;
        if (s_ack_i) begin
          state_d = REL;
        end else if (!s_stb_o) begin
          state_d = IDLE;
        end else if (tmo_q == TIMEOUT) begin
          // Abort: fake an error ack so the master unblocks.
          s_stb_o   = 1'b0;
          timeout_o = 1'b1;
          rd_ack    = 1'b1;
          rd_dat    = 8'hFF;
          state_d   = REL;
        end
      end
      REL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = 2'b00;
    unique case (state_d)
      GNT0:    grant_d = 2'b01;
      GNT1:    grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  assign grant_o  = grant_q;
  assign m0_ack_o = grant_q[0] & rd_ack;
  assign m1_ack_o = grant_q[1] & rd_ack;
  assign m0_dat_o = grant_q[0] ? rd_dat : 8'h00;
  assign m1_dat_o = grant_q[1] ? rd_dat : 8'h00;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: read, tie, timeout,
// ack-at-timeout, abandon and mid-grant reset.
module tb_wb_arbiter;

  localparam logic [7:0] TMO = 8'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] m0_addr, m0_dat, m1_addr, m1_dat;
  logic       m0_stb, m0_we, m1_stb, m1_we;
  logic [7:0] m0_rd, m1_rd;
  logic       m0_ack, m1_ack;
  logic [7:0] s_addr, s_wdat, s_rdat;
  logic       s_stb, s_we, s_ack;
  logic [1:0] grant;
  logic       tmo;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0_addr_i(m0_addr),
    .m0_dat_i (m0_dat),
    .m0_stb_i (m0_stb),
    .m0_we_i  (m0_we),
    .m0_dat_o (m0_rd),
    .m0_ack_o (m0_ack),
    .m1_addr_i(m1_addr),
    .m1_dat_i (m1_dat),
    .m1_stb_i (m1_stb),
    .m1_we_i  (m1_we),
    .m1_dat_o (m1_rd),
    .m1_ack_o (m1_ack),
    .s_addr_o (s_addr),
    .s_dat_o  (s_wdat),
    .s_stb_o  (s_stb),
    .s_we_o   (s_we),
    .s_dat_i  (s_rdat),
    .s_ack_i  (s_ack),
    .grant_o  (grant),
    .timeout_o(tmo)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [1:0] tie_exp [9];
  int npulse;

  initial begin
    tie_exp = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00,
                2'b00, 2'b01, 2'b00, 2'b00};
    rst = 1'b1;
    {m0_addr, m0_dat, m0_stb, m0_we} = '0;
    {m1_addr, m1_dat, m1_stb, m1_we} = '0;
    s_rdat = 8'h5A;
    s_ack = 1'b0;
    tick();
    tick();
    smp();
    chk("rst_grant", grant, 2'b00);
    chk("rst_stb", s_stb, 1'b0);
    chk("rst_addr", s_addr, 8'h00);
    chk("rst_m0dat", m0_rd, 8'h00);
    chk("rst_tmo", tmo, 1'b0);

    // single read, slave acks on 3rd grant cycle
    tick();
    rst = 1'b0;
    m0_addr = 8'h12;
    m0_stb = 1'b1;
    tick();
    smp();
    chk("rd_grant", grant, 2'b01);
    chk("rd_addr", s_addr, 8'h12);
    chk("rd_stb", s_stb, 1'b1);
    chk("rd_noack", m0_ack, 1'b0);
    tick();
    tick();
    s_ack = 1'b1;
    s_rdat = 8'hA5;
    smp();
    chk("rd_ack", m0_ack, 1'b1);
    chk("rd_dat", m0_rd, 8'hA5);
    chk("rd_m1ack", m1_ack, 1'b0);
    chk("rd_m1dat", m1_rd, 8'h00);
    chk("rd_gnt2", grant, 2'b01);
    tick();
    m0_stb = 1'b0;
    s_ack = 1'b0;
    tick();
    smp();
    chk("rel_grant", grant, 2'b00);
    chk("rel_stb", s_stb, 1'b0);
    s_ack = 1'b1;
    smp();
    chk("rel_ign_ack", m0_ack, 1'b0);
    tick();
    smp();
    chk("idle_grant", grant, 2'b00);
    chk("idle_ign_ack", m0_ack, 1'b0);
    s_ack = 1'b0;

    // tie with zero-wait slave, reset first
    rst = 1'b1;
    m0_stb = 1'b1;
    m1_stb = 1'b1;
    m1_addr = 8'h77;
    tick();
    rst = 1'b0;
    s_ack = 1'b1;
    s_rdat = 8'h11;
    for (int i = 0; i < 9; i++) begin
      tick();
      smp();
      chk($sformatf("tie_g%0d", i), grant, tie_exp[i]);
      chk($sformatf("tie_a0_%0d", i), m0_ack,
          tie_exp[i][0]);
      chk($sformatf("tie_a1_%0d", i), m1_ack,
          tie_exp[i][1]);
    end
    if (grant == 2'b10)
      chk("tie_addr1", s_addr, 8'h77);
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    s_ack = 1'b0;
    tick();
    tick();

    // timeout: m1 write, slave silent
    m1_addr = 8'h34;
    m1_dat = 8'h77;
    m1_we = 1'b1;
    m1_stb = 1'b1;
    npulse = 0;
    for (int i = 0; i <= int'(TMO); i++) begin
      tick();
      smp();
      if (tmo) npulse++;
      chk($sformatf("to_g%0d", i), grant, 2'b10);
      chk($sformatf("to_p%0d", i), tmo,
          (i == int'(TMO)) ? 1'b1 : 1'b0);
      if (i == 0) begin
        chk("to_we", s_we, 1'b1);
        chk("to_wdat", s_wdat, 8'h77);
      end
    end
    chk("to_ack", m1_ack, 1'b1);
    chk("to_dat", m1_rd, 8'hFF);
    chk("to_stb", s_stb, 1'b0);
    chk("to_m0ack", m0_ack, 1'b0);
    tick();
    m1_stb = 1'b0;
    m1_we = 1'b0;
    smp();
    if (tmo) npulse++;
    chk("to_rel", grant, 2'b00);
    chk("to_pulses", npulse, 1);
    tick();

    // ack exactly at the timeout cycle
    m0_stb = 1'b1;
    m0_addr = 8'h40;
    for (int i = 0; i < int'(TMO); i++) tick();
    tick();
    s_ack = 1'b1;
    s_rdat = 8'h3C;
    smp();
    chk("at_ack", m0_ack, 1'b1);
    chk("at_dat", m0_rd, 8'h3C);
    chk("at_tmo", tmo, 1'b0);
    tick();
    m0_stb = 1'b0;
    s_ack = 1'b0;
    tick();

    // abandon: m0 drops stb mid-grant
    m0_stb = 1'b1;
    tick();
    tick();
    smp();
    chk("ab_grant", grant, 2'b01);
    m0_stb = 1'b0;
    smp();
    chk("ab_noack", m0_ack, 1'b0);
    chk("ab_notmo", tmo, 1'b0);
    tick();
    m1_stb = 1'b1;
    smp();
    chk("ab_idle", grant, 2'b00);
    tick();
    smp();
    chk("ab_m1gnt", grant, 2'b10);

    // reset during GNT1
    rst = 1'b1;
    tick();
    s_ack = 1'b1;
    smp();
    chk("mr_grant", grant, 2'b00);
    chk("mr_noack", m1_ack, 1'b0);
    chk("mr_stb", s_stb, 1'b0);
    rst = 1'b0;
    s_ack = 1'b0;
    tick();
    smp();
    chk("mr_regnt", grant, 2'b10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8'd255, meaning grant-state cycles allowed before a cycle is aborted.
REQ-002 The block SHALL have port wb_clk_i  input  1  the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port wb_rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have ports m0_addr_i, m0_dat_i  input  8 each  master 0 (SPI controller) address and write data.
REQ-005 The block SHALL have ports m0_stb_i, m0_we_i  input  1 each, and m0_dat_o  output  8, m0_ack_o  output  1  master 0 strobe, write-enable, read data and acknowledge.
REQ-006 The block SHALL have ports m1_* identical to m0_*, serving master 1 (MIDI routing engine).
REQ-007 The block SHALL have ports s_addr_o, s_dat_o  output  8 each, s_stb_o, s_we_o  output  1 each  to the shared register slave.
REQ-008 The block SHALL have ports s_dat_i  input  8 and s_ack_i  input  1  slave read data and acknowledge.
REQ-009 The block SHALL have ports grant_o  output  2 (one-hot, bit n = master n owns bus) and timeout_o  output  1 (one-cycle abort pulse).

Function
REQ-010 The FSM SHALL have states IDLE, GNT0, GNT1 and REL, held in a registered state variable.
REQ-011 IDLE: with only mN_stb_i high, the FSM SHALL enter GNTN on the next edge; with neither high, it SHALL remain in IDLE.
REQ-012 IDLE with both strobes high SHALL grant the master not granted most recently (round-robin pointer last_q); last_q SHALL reset to 1 so master 0 wins the first tie.
REQ-013 last_q SHALL update to N on every entry into GNTN.
REQ-014 In GNTN, s_addr_o, s_dat_o and s_we_o SHALL equal master N's inputs combinationally, and s_stb_o SHALL equal mN_stb_i.
REQ-015 Outside GNT0/GNT1, s_stb_o and s_we_o SHALL be 0, and s_addr_o and s_dat_o SHALL be 8'h00.
REQ-016 mN_dat_o SHALL equal s_dat_i while grant_o[N]=1 and 8'h00 otherwise, except as stated in REQ-020.
REQ-017 mN_ack_o SHALL equal s_ack_i gated by grant_o[N]; a non-granted master SHALL never see ack.
REQ-018 In GNTN, s_ack_i=1 SHALL move the FSM to REL on the next edge; REL SHALL last exactly 1 cycle, then go to IDLE, so the master can drop stb before re-arbitration.
REQ-019 In GNTN, mN_stb_i=0 before any ack (abandoned cycle) SHALL return the FSM to IDLE on the next edge, with no ack and no timeout.
REQ-020 The 8-bit counter tmo_q SHALL clear on grant entry and increment each GNT cycle; on tmo_q==TIMEOUT without s_ack_i: mN_ack_o=1, mN_dat_o=8'hFF and timeout_o=1 for that cycle, s_stb_o=0 that cycle, and the next state is REL.
REQ-021 s_ack_i in the same cycle as tmo_q==TIMEOUT SHALL count as a normal ack: slave data is returned and timeout_o stays 0.
REQ-022 s_ack_i while in IDLE or REL SHALL be ignored, with no state change and no master ack.
REQ-023 grant_o SHALL be registered, decoded from state: GNT0 gives 2'b01, GNT1 gives 2'b10, any other state gives 2'b00; grant_o SHALL never be 2'b11.
REQ-024 Minimum latency SHALL be stb asserted at edge k, giving grant and s_stb_o after edge k+1; a zero-wait slave acks in that same cycle.

Reset
REQ-025 wb_rst_i=1 at an edge SHALL force state to IDLE, last_q to 1, tmo_q to 0, grant_o to 2'b00 and timeout_o to 0, so that all s_* outputs and m*_ack_o read 0 and m*_dat_o read 8'h00.
REQ-026 Reset asserted mid-transfer (GNTN) SHALL abort the transfer without an ack; after release, a still-high strobe SHALL be re-arbitrated from IDLE.

Verification
REQ-027 Single read: m0 reads addr 8'h12 and the slave acks 2 cycles later with 8'hA5 -> m0_dat_o=8'hA5 with m0_ack_o=1, grant_o=01, then REL, then IDLE.
REQ-028 Tie: both masters strobe continuously with zero-wait slave acks -> grants alternate 01,10,01,10, with m0 first after reset.
REQ-029 Timeout: m1 writes and the slave never acks -> after TIMEOUT+1 grant cycles, m1_ack_o=1, m1_dat_o=8'hFF, timeout_o pulses once and s_stb_o drops.
REQ-030 Ack at the timeout cycle: s_ack_i=1 with 8'h3C exactly when tmo_q==TIMEOUT -> m0 gets 8'h3C and timeout_o=0.
REQ-031 Abandon/reset: m0 drops stb mid-grant -> IDLE, no ack; wb_rst_i pulsed during GNT1 -> grant_o=00 next cycle, and m1 is re-granted after reset deasserts.
